// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx -- UART receiver, counterpart of the team's UART transmit path.
//
// Frame: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit,
// stop bit (1). The line is oversampled at PRESCALE clocks per bit and each
// bit is taken near the middle of its window.
//
// Optional feature (compile-time macro UART_RX_MAJORITY_EN):
//   defined   -> each bit is the majority of three samples taken at
//                edge_cnt = PRESCALE/2-2, PRESCALE/2-1, PRESCALE/2; the decision
//                is made at PRESCALE/2 (one cycle later than the default).
//   undefined -> single sample at edge_cnt = PRESCALE/2-1.
//
// Parameters:
//   PRESCALE    clocks per bit (even, >= 4)
//   DATA_WIDTH  data bits per frame
//
// Ports:
//   CLK            system clock, rising edge
//   RST            synchronous, active-high reset
//   RX_IN          asynchronous serial line, idles high
//   parity_enable  1 = frame carries a parity bit (latched at start detection)
//   parity_type    0 = even, 1 = odd (latched at start detection)
//   P_DATA         last good byte; holds until the next valid frame
//   Data_Valid     one-cycle strobe, P_DATA valid in that cycle
//   parity_error   one-cycle strobe, parity mismatch
//   stop_error     one-cycle strobe, stop bit sampled 0
//   busy           high whenever the FSM is not IDLE
//
// Handshake: Data_Valid is a pure strobe with no ready/backpressure; the
// consumer must take P_DATA in the cycle Data_Valid is high (P_DATA also
// holds afterwards until the next good frame).
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int PRESCALE   = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] EARLY_CNT  = CNT_W'(PRESCALE / 2 - 2);
    localparam logic [CNT_W-1:0] MID_CNT    = CNT_W'(PRESCALE / 2 - 1);
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(PRESCALE / 2);
`else
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(PRESCALE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic                  rx_meta;
    logic                  rx_s;
    logic [CNT_W-1:0]      edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  par_err_q;

    logic                  sample_pt;
    logic                  window_end;
    logic                  bit_val;
    logic                  detect;
    logic                  frame_done;

    // ------------------------------------------------------------------
    // Two-flop synchronizer; everything downstream uses rx_s only.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX_IN;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Bit value decision
    // ------------------------------------------------------------------
`ifdef UART_RX_MAJORITY_EN
    logic s_early;
    logic s_mid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s_early <= 1'b1;
            s_mid   <= 1'b1;
        end else begin
            if (edge_cnt == EARLY_CNT) s_early <= rx_s;
            if (edge_cnt == MID_CNT)   s_mid   <= rx_s;
        end
    end

    assign bit_val = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign sample_pt  = (edge_cnt == SAMPLE_CNT);
    assign window_end = (edge_cnt == LAST_CNT);
    assign detect     = (state == IDLE) && !rx_s;
    assign frame_done = (state == STOP) && sample_pt;
    assign busy       = (state != IDLE);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (!rx_s) next_state = START;
            end
            START: begin
                // A high line at the start sample means the falling edge
                // was a glitch.
                if (sample_pt && bit_val) next_state = IDLE;
                else if (window_end)      next_state = DATA;
            end
            DATA: begin
                if (window_end && (bit_cnt == LAST_BIT))
                    next_state = par_en_q ? PARITY : STOP;
            end
            PARITY: begin
                if (window_end) next_state = STOP;
            end
            STOP: begin
                // Leave at the stop sample so a following start bit can be
                // caught without waiting out the stop window.
                if (sample_pt) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Counters. The detection cycle counts as edge_cnt 0 of the start
    // window, so the counter is already 1 in the first START cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            edge_cnt <= '0;
        end else if (next_state == IDLE) begin
            edge_cnt <= '0;
        end else if (window_end) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt <= '0;
        end else if (state != DATA) begin
            bit_cnt <= '0;
        end else if (window_end) begin
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, frame config, parity check
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            if (detect) begin
                par_en_q   <= parity_enable;
                par_type_q <= parity_type;
                par_err_q  <= 1'b0;
            end
            // LSB arrives first, so shifting in at the MSB end leaves the
            // first bit in bit 0 once the byte is complete.
            if ((state == DATA) && sample_pt)
                shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
            if ((state == PARITY) && sample_pt)
                par_err_q <= (bit_val != ((^shift_reg) ^ par_type_q));
        end
    end

    // ------------------------------------------------------------------
    // Output strobes, registered one cycle after the stop sample.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            P_DATA       <= '0;
            Data_Valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            Data_Valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            if (frame_done) begin
                stop_error   <= !bit_val;
                parity_error <= par_err_q;
                if (bit_val && !par_err_q) begin
                    Data_Valid <= 1'b1;
                    P_DATA     <= shift_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx (PRESCALE = 8).
// RX_IN is driven on falling clock edges; outputs are observed on falling
// edges. A frame's "fall cycle" is the value of cyc when the start bit is
// driven; Data_Valid is then expected at fall + 78 (2 synchronizer cycles +
// 76 from detection), +8 with parity, +1 with the majority-vote build.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int PRESCALE = 8;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam int LAT_NP = 78 + MAJ;
    localparam int LAT_P  = 86 + MAJ;

    // ---------------- clock / reset ----------------
    logic       CLK;
    logic       RST;
    logic       RX_IN;
    logic       parity_enable;
    logic       parity_type;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       parity_error;
    logic       stop_error;
    logic       busy;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    uart_rx #(.PRESCALE(PRESCALE), .DATA_WIDTH(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .P_DATA       (P_DATA),
        .Data_Valid   (Data_Valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    // ---------------- scoreboard / monitor ----------------
    int         checks = 0;
    int         errors = 0;
    int         dv_cyc_q[$];
    logic [7:0] dv_data_q[$];
    int         pe_cyc_q[$];
    int         se_cyc_q[$];

    always @(negedge CLK) begin
        if (Data_Valid) begin
            dv_cyc_q.push_back(cyc);
            dv_data_q.push_back(P_DATA);
        end
        if (parity_error) pe_cyc_q.push_back(cyc);
        if (stop_error)   se_cyc_q.push_back(cyc);
    end

    task automatic clear_mon();
        dv_cyc_q.delete();
        dv_data_q.delete();
        pe_cyc_q.delete();
        se_cyc_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // ---------------- driver ----------------
    // stop_low: number of leading cycles of the stop window driven low
    // (0 = good stop). glitch_bit: data bit whose centre cycle is inverted
    // for one clock (-1 = none).
    task automatic send_frame(input logic [7:0] data, input bit par_on,
                              input bit par_bit, input int stop_low,
                              input int glitch_bit, output int fall_cyc);
        logic v;
        int   nbits;
        nbits    = par_on ? 11 : 10;
        fall_cyc = 0;
        for (int b = 0; b < nbits; b++) begin
            for (int i = 0; i < PRESCALE; i++) begin
                @(negedge CLK);
                if (b == 0)                   v = 1'b0;
                else if (b <= 8)              v = data[b-1];
                else if (par_on && b == 9)    v = par_bit;
                else                          v = (i < stop_low) ? 1'b0 : 1'b1;
                if (b >= 1 && b <= 8 && (b - 1) == glitch_bit && i == PRESCALE/2 - 1)
                    v = ~v;
                RX_IN = v;
                if (b == 0 && i == 0) fall_cyc = cyc;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RST = 1'b1; RX_IN = 1'b1; parity_enable = 1'b0; parity_type = 1'b0;
        idle(3);
        checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_p_data: got %h want 00", P_DATA); end
        checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", Data_Valid); end
        checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL reset_pe: got %b want 0", parity_error); end
        checks++; if (stop_error !== 1'b0) begin errors++; $display("FAIL reset_se: got %b want 0", stop_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        RST = 1'b0;
        idle(5);
    endtask

    task automatic test_no_parity();
        int f;
        clear_mon();
        parity_enable = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 0, -1, f);
        idle(6);
        checks++; if (dv_cyc_q.size() != 1) begin errors++; $display("FAIL np_dv_count: got %0d want 1", dv_cyc_q.size()); end
        checks++; if (((dv_cyc_q.size() > 0) ? dv_cyc_q[0] : -1) != f + LAT_NP) begin errors++; $display("FAIL np_latency: got %0d want %0d", (dv_cyc_q.size() > 0) ? dv_cyc_q[0] - f : -1, LAT_NP); end
        checks++; if (P_DATA !== 8'hA5) begin errors++; $display("FAIL np_data: got %h want a5", P_DATA); end
        checks++; if (pe_cyc_q.size() != 0) begin errors++; $display("FAIL np_pe: got %0d strobes want 0", pe_cyc_q.size()); end
        checks++; if (se_cyc_q.size() != 0) begin errors++; $display("FAIL np_se: got %0d strobes want 0", se_cyc_q.size()); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL np_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_parity_even();
        int f;
        parity_enable = 1'b1; parity_type = 1'b0;
        clear_mon();
        send_frame(8'h3C, 1'b1, 1'b0, 0, -1, f);
        idle(6);
        checks++; if (dv_cyc_q.size() != 1) begin errors++; $display("FAIL even_dv_count: got %0d want 1", dv_cyc_q.size()); end
        checks++; if (((dv_cyc_q.size() > 0) ? dv_cyc_q[0] : -1) != f + LAT_P) begin errors++; $display("FAIL even_latency: got %0d want %0d", (dv_cyc_q.size() > 0) ? dv_cyc_q[0] - f : -1, LAT_P); end
        checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL even_data: got %h want 3c", P_DATA); end
        // same byte, wrong parity bit
        clear_mon();
        send_frame(8'h3C, 1'b1, 1'b1, 0, -1, f);
        idle(6);
        checks++; if (pe_cyc_q.size() != 1) begin errors++; $display("FAIL even_pe_count: got %0d want 1", pe_cyc_q.size()); end
        checks++; if (((pe_cyc_q.size() > 0) ? pe_cyc_q[0] : -1) != f + LAT_P) begin errors++; $display("FAIL even_pe_latency: got %0d want %0d", (pe_cyc_q.size() > 0) ? pe_cyc_q[0] - f : -1, LAT_P); end
        checks++; if (dv_cyc_q.size() != 0) begin errors++; $display("FAIL even_pe_no_dv: got %0d strobes want 0", dv_cyc_q.size()); end
        checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL even_pe_hold: got %h want 3c", P_DATA); end
    endtask

    task automatic test_parity_odd();
        int f;
        parity_enable = 1'b1; parity_type = 1'b1;
        clear_mon();
        // parity_type flips to even mid-frame; the latched odd setting must hold.
        fork
            send_frame(8'h01, 1'b1, 1'b0, 0, -1, f);
            begin idle(30); parity_type = 1'b0; end
        join
        idle(6);
        parity_type = 1'b1;
        checks++; if (dv_cyc_q.size() != 1) begin errors++; $display("FAIL odd_dv_count: got %0d want 1", dv_cyc_q.size()); end
        checks++; if (P_DATA !== 8'h01) begin errors++; $display("FAIL odd_data: got %h want 01", P_DATA); end
        checks++; if (pe_cyc_q.size() != 0) begin errors++; $display("FAIL odd_pe: got %0d strobes want 0", pe_cyc_q.size()); end
    endtask

    task automatic test_stop_error();
        int f;
        parity_enable = 1'b0;
        clear_mon();
        // Stop driven low only across the sample cycles, so the line is high
        // again when the receiver returns to IDLE (no phantom start).
        send_frame(8'h55, 1'b0, 1'b0, 4, -1, f);
        idle(20);
        checks++; if (se_cyc_q.size() != 1) begin errors++; $display("FAIL stop_se_count: got %0d want 1", se_cyc_q.size()); end
        checks++; if (((se_cyc_q.size() > 0) ? se_cyc_q[0] : -1) != f + LAT_NP) begin errors++; $display("FAIL stop_se_latency: got %0d want %0d", (se_cyc_q.size() > 0) ? se_cyc_q[0] - f : -1, LAT_NP); end
        checks++; if (dv_cyc_q.size() != 0) begin errors++; $display("FAIL stop_no_dv: got %0d strobes want 0", dv_cyc_q.size()); end
        checks++; if (P_DATA !== 8'h01) begin errors++; $display("FAIL stop_hold: got %h want 01", P_DATA); end
    endtask

    task automatic test_glitch();
        int f;
        clear_mon();
        @(negedge CLK); RX_IN = 1'b0; f = cyc;
        @(negedge CLK);
        @(negedge CLK); RX_IN = 1'b1;
        idle(2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_high: got %b want 1 at fall+%0d", busy, cyc - f); end
        idle(12);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_low: got %b want 0", busy); end
        checks++; if (dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size() != 0) begin errors++; $display("FAIL glitch_no_strobe: got %0d strobes want 0", dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size()); end
        send_frame(8'h80, 1'b0, 1'b0, 0, -1, f);
        idle(6);
        checks++; if (dv_cyc_q.size() != 1) begin errors++; $display("FAIL glitch_next_dv: got %0d want 1", dv_cyc_q.size()); end
        checks++; if (P_DATA !== 8'h80) begin errors++; $display("FAIL glitch_next_data: got %h want 80", P_DATA); end
    endtask

    task automatic test_back_to_back();
        int f1, f2;
        clear_mon();
        send_frame(8'h12, 1'b0, 1'b0, 0, -1, f1);
        send_frame(8'h34, 1'b0, 1'b0, 0, -1, f2);
        idle(6);
        checks++; if (dv_cyc_q.size() != 2) begin errors++; $display("FAIL b2b_dv_count: got %0d want 2", dv_cyc_q.size()); end
        checks++; if (((dv_data_q.size() > 0) ? dv_data_q[0] : 8'hxx) !== 8'h12) begin errors++; $display("FAIL b2b_data0: got %h want 12", (dv_data_q.size() > 0) ? dv_data_q[0] : 8'hxx); end
        checks++; if (((dv_data_q.size() > 1) ? dv_data_q[1] : 8'hxx) !== 8'h34) begin errors++; $display("FAIL b2b_data1: got %h want 34", (dv_data_q.size() > 1) ? dv_data_q[1] : 8'hxx); end
        checks++; if (((dv_cyc_q.size() > 0) ? dv_cyc_q[0] : -1) != f1 + LAT_NP) begin errors++; $display("FAIL b2b_lat0: got %0d want %0d", (dv_cyc_q.size() > 0) ? dv_cyc_q[0] - f1 : -1, LAT_NP); end
        checks++; if (((dv_cyc_q.size() > 1) ? dv_cyc_q[1] : -1) != f1 + 80 + LAT_NP) begin errors++; $display("FAIL b2b_lat1: got %0d want %0d", (dv_cyc_q.size() > 1) ? dv_cyc_q[1] - f1 : -1, 80 + LAT_NP); end
    endtask

    task automatic test_reset_midframe();
        int f;
        clear_mon();
        fork
            send_frame(8'hFF, 1'b0, 1'b0, 0, -1, f);
            begin
                // negedge fall+44 lies inside data bit 4
                idle(45);
                RST = 1'b1;
                @(negedge CLK);
                checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL mrst_p_data: got %h want 00", P_DATA); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
                checks++; if (Data_Valid !== 1'b0) begin errors++; $display("FAIL mrst_dv: got %b want 0", Data_Valid); end
                RST = 1'b0;
            end
        join
        idle(6);
        checks++; if (dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size() != 0) begin errors++; $display("FAIL mrst_no_strobe: got %0d strobes want 0", dv_cyc_q.size() + pe_cyc_q.size() + se_cyc_q.size()); end
        send_frame(8'h0F, 1'b0, 1'b0, 0, -1, f);
        idle(6);
        checks++; if (P_DATA !== 8'h0F) begin errors++; $display("FAIL mrst_next_data: got %h want 0f", P_DATA); end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority();
        int f;
        clear_mon();
        send_frame(8'h5A, 1'b0, 1'b0, 0, 2, f);
        idle(6);
        checks++; if (dv_cyc_q.size() != 1) begin errors++; $display("FAIL maj_dv_count: got %0d want 1", dv_cyc_q.size()); end
        checks++; if (P_DATA !== 8'h5A) begin errors++; $display("FAIL maj_data: got %h want 5a", P_DATA); end
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_no_parity();
        idle(10);
        test_parity_even();
        idle(10);
        test_parity_odd();
        idle(10);
        test_stop_error();
        idle(10);
        test_glitch();
        idle(10);
        test_back_to_back();
        idle(10);
        test_reset_midframe();
`ifdef UART_RX_MAJORITY_EN
        idle(10);
        test_majority();
`endif
        idle(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the team's UART transmit path. It consumes the serial line produced by the transmitter and returns parallel bytes.
- Frame format: start bit (0), 8 data bits LSB first, optional parity bit, stop bit (1).
- Line is oversampled at PRESCALE clocks per bit; each bit is sampled mid-window.
- Received byte is presented on P_DATA with a one-cycle Data_Valid strobe; parity and framing errors are flagged separately.

Parameters:
- PRESCALE, 8, clocks per bit; must be even and >= 4.
- DATA_WIDTH, 8, data bits per frame.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- RX_IN  input  1  asynchronous serial line; idles high.
- parity_enable  input  1  1 = frame carries a parity bit.
- parity_type  input  1  0 = even, 1 = odd.
- P_DATA  output  DATA_WIDTH  received byte; holds until the next valid frame.
- Data_Valid  output  1  one-cycle strobe; P_DATA valid in that cycle.
- parity_error  output  1  one-cycle strobe; parity mismatch.
- stop_error  output  1  one-cycle strobe; stop bit sampled 0.
- busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset values (RST=1 at a clock edge): state IDLE, counters 0, P_DATA=0, Data_Valid=0, parity_error=0, stop_error=0, busy=0, synchronizer flops=1.
- Synchronizer: RX_IN passes through a 2-flop synchronizer; all decisions use the synced value rx_s. This adds 2 cycles of latency.
- Counters:
  - edge_cnt: width clog2(PRESCALE); counts 0..PRESCALE-1, wraps to 0 at the end of each bit window.
  - bit_cnt: counts 0..DATA_WIDTH-1.
- Sample point: the single cycle where edge_cnt == PRESCALE/2-1.
- FSM states:
  - IDLE:
    - When rx_s==0: go to START with edge_cnt=0 in the same cycle; this is the detection cycle.
    - Latch parity_enable and parity_type into internal config regs at detection. Config is stable for the whole frame.
  - START: at the sample point, a sample of 1 is a glitch → return to IDLE with no strobes. A sample of 0 → go to DATA at the window end.
  - DATA:
    - At each sample point, shift the sample into the shift register at the MSB end (LSB-first reception).
    - At the window end: bit_cnt increments. After bit DATA_WIDTH-1, go to PARITY if parity is enabled, else STOP.
  - PARITY: at the sample point, compute expected parity = XOR(shift reg) XOR parity_type. Store mismatch flag. Go to STOP at the window end.
  - STOP:
    - At the sample point, evaluate the frame and go to IDLE immediately (next cycle). The remaining half of the stop bit is not waited for, so back-to-back frames are accepted.
    - Next cycle, if stop sample==1 and no parity mismatch: P_DATA <= shift reg, Data_Valid=1 for exactly one cycle.
    - If stop sample==0: stop_error=1 for one cycle, no Data_Valid, P_DATA unchanged.
    - If parity mismatch: parity_error=1 for one cycle, no Data_Valid, P_DATA unchanged.
    - If both errors: both strobes assert in the same cycle.
- Latency (PRESCALE=8, no parity): stop sampled 9*8+3 = 75 cycles after detection; Data_Valid at detection+76. Detection is 2 cycles after RX_IN falls (synchronizer). With parity: detection+84.
- RX_IN is not checked between sample points. Glitches outside sample points are ignored, except in IDLE.
- Reset mid-frame: return to IDLE next edge. No strobes; P_DATA cleared to 0.
- Changes to parity_enable or parity_type mid-frame have no effect until the next detection.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value is the majority of 3 samples taken at edge_cnt = PRESCALE/2-2, PRESCALE/2-1, PRESCALE/2. The decision is made at PRESCALE/2, so every sample point and the latencies above shift +1 cycle (Data_Valid at detection+77, no parity).
- Undefined: single sample at PRESCALE/2-1 as specified above.

Test Plan:
- PRESCALE=8, parity off, frame 0xA5 with correct stop → Data_Valid one cycle at detection+76, P_DATA=0xA5, both error strobes 0, busy low after.
- Parity on, even, frame 0x3C with parity bit 0 → P_DATA=0x3C, Data_Valid at detection+84. Same frame with parity bit 1 → parity_error one cycle, no Data_Valid, P_DATA keeps previous value.
- Parity on, odd, 0x01 with parity 0 → Data_Valid, P_DATA=0x01. Frame 0x55 with stop bit 0 → stop_error one cycle, no Data_Valid.
- 2-cycle low pulse on idle line → FSM returns to IDLE after the start sample, no strobes. Then frame 0x80 → P_DATA=0x80.
- Back-to-back frames 0x12 then 0x34 with no idle gap → two Data_Valid strobes, P_DATA=0x12 then 0x34.
- RST=1 for one cycle during DATA bit 4 of frame 0xFF → outputs at reset values next cycle, no strobe. Then frame 0x0F → P_DATA=0x0F. With UART_RX_MAJORITY_EN defined, a 1-cycle flip at a data-bit centre sample does not corrupt P_DATA.
